// File: rtl/uart_defs.sv
// Shared UART hex-ASCII definitions: character constants, frame length and the
// transmit state encoding used by uart_num_asc.
package uart_defs;

    localparam logic [7:0] ASC_0  = 8'h30;
    localparam logic [7:0] ASC_UA = 8'h41;
    localparam logic [7:0] ASC_LA = 8'h61;
    localparam logic [7:0] ASC_CR = 8'h0D;
    localparam logic [7:0] ASC_LF = 8'h0A;

    localparam int FRAME_CHARS = 24;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        GAP  = 2'd2,
        DONE = 2'd3
    } state_t;

endpackage

// File: rtl/hex_to_asc.sv
// Combinational nibble-to-ASCII converter; letters are upper or lower case
// depending on i_lowerCase.
module hex_to_asc
    import uart_defs::*;
(
    input  logic [3:0] i_nibble,
    input  logic       i_lowerCase,
    output logic [7:0] o_asc
);

    logic [7:0] w_nibbleExt;

    assign w_nibbleExt = {4'h0, i_nibble};

    always_comb begin
        if (i_nibble < 4'd10) begin
            o_asc = ASC_0 + w_nibbleExt;
        end else if (i_lowerCase) begin
            o_asc = ASC_LA + w_nibbleExt - 8'd10;
        end else begin
            o_asc = ASC_UA + w_nibbleExt - 8'd10;
        end
    end

endmodule

// File: rtl/uart_num_asc.sv
// Serialises latched x/y/z words as 24 ASCII hex characters over a valid/ready
// byte interface. Define UART_NUM_ASC_CRLF_EN to append CR LF to every frame.
module uart_num_asc
    import uart_defs::*;
#(
    parameter bit LOWER_CASE = 1'b0,
    parameter int GAP_CYCLES = 0
)
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        clr,
    input  logic [31:0] xdatain,
    input  logic [31:0] ydatain,
    input  logic [31:0] zdatain,
    input  logic        tx_ready,
    output logic        tx_valid,
    output logic [7:0]  asc,
    output logic        busy,
    output logic        done
);

`ifdef UART_NUM_ASC_CRLF_EN
    localparam int TOTAL_CHARS = FRAME_CHARS + 2;
`else
    localparam int TOTAL_CHARS = FRAME_CHARS;
`endif
    localparam logic [4:0] LAST_IDX = 5'(TOTAL_CHARS - 1);
    localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    state_t           r_state;
    state_t           w_nextState;
    logic             r_startPrev;
    logic [95:0]      r_shift;
    logic [4:0]       r_count;
    logic [GAP_W-1:0] r_gapCnt;
    logic             w_launch;
    logic             w_xfer;
    logic             w_last;
    logic [7:0]       w_hexAsc;
    logic [7:0]       w_charAsc;

    hex_to_asc u_hexToAsc (
        .i_nibble    (r_shift[95:92]),
        .i_lowerCase (LOWER_CASE),
        .o_asc       (w_hexAsc)
    );

    // Launch only on a fresh rising edge of start while idle; edges during a frame are ignored.
    assign w_launch = start & ~r_startPrev & (r_state == IDLE);
    assign w_xfer   = (r_state == SEND) & tx_ready;
    assign w_last   = (r_count == LAST_IDX);

`ifdef UART_NUM_ASC_CRLF_EN
    always_comb begin
        w_charAsc = w_hexAsc;
        if (r_count == 5'(FRAME_CHARS)) begin
            w_charAsc = ASC_CR;
        end else if (r_count == 5'(FRAME_CHARS + 1)) begin
            w_charAsc = ASC_LF;
        end
    end
`else
    assign w_charAsc = w_hexAsc;
`endif

    assign tx_valid = (r_state == SEND);
    assign asc      = tx_valid ? w_charAsc : 8'h00;
    assign busy     = (r_state != IDLE);
    assign done     = (r_state == DONE);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // clr overrides every transition, including a launch in the same cycle.
    always_comb begin
        w_nextState = r_state;
        if (clr) begin
            w_nextState = IDLE;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (w_launch) begin
                        w_nextState = SEND;
                    end
                end
                SEND: begin
                    if (w_xfer) begin
                        if (w_last) begin
                            w_nextState = DONE;
                        end else if (GAP_CYCLES > 0) begin
                            w_nextState = GAP;
                        end else begin
                            w_nextState = SEND;
                        end
                    end
                end
                GAP: begin
                    if (r_gapCnt == '0) begin
                        w_nextState = SEND;
                    end
                end
                DONE: begin
                    w_nextState = IDLE;
                end
                default: begin
                    w_nextState = IDLE;
                end
            endcase
        end
    end

    // The shift register is latched at launch, so later input changes cannot disturb the frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_startPrev <= 1'b0;
            r_shift     <= '0;
            r_count     <= '0;
            r_gapCnt    <= '0;
        end else begin
            r_startPrev <= start;
            if (clr) begin
                r_count  <= '0;
                r_gapCnt <= '0;
            end else if (w_launch) begin
                r_shift <= {xdatain, ydatain, zdatain};
                r_count <= '0;
            end else if (w_xfer) begin
                r_shift  <= {r_shift[91:0], 4'h0};
                r_count  <= r_count + 5'd1;
                r_gapCnt <= GAP_LOAD;
            end else if ((r_state == GAP) && (r_gapCnt != '0)) begin
                r_gapCnt <= r_gapCnt - 1'b1;
            end
        end
    end

endmodule
